// File: rtl/vram_pkg.sv
// Shared sizes and fill-state encoding for the video RAM CPU-port arbiter.
package vram_pkg;
  localparam int VRAM_ADDR_W        = 13;
  localparam int VRAM_DATA_W        = 8;
  localparam int VRAM_BYTES_PER_ROW = 40;
  localparam int VRAM_ROWS          = 192;
  localparam int VRAM_LIMIT         = VRAM_BYTES_PER_ROW * VRAM_ROWS;

  typedef enum logic [1:0] {
    FILL_IDLE = 2'd0,
    FILL_RUN  = 2'd1,
    FILL_DONE = 2'd2
  } fillState_t;
endpackage

// File: rtl/vram_fill_engine.sv
// Block-fill engine: writes one byte per grant, requesting the port for its whole run.
// Busy follows the start edge; done pulses one cycle after the last write; abort drops silently.
module vram_fill_engine
  import vram_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] startAddr,
  input  logic [ADDR_W-1:0] startLen,
  input  logic [DATA_W-1:0] startValue,
  input  logic              grant,
  output logic              req,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] value,
  output logic              busy,
  output logic              done
);
  fillState_t        state;
  logic [ADDR_W-1:0] cntQ;

  assign req = (state == FILL_RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FILL_IDLE;
      addr  <= '0;
      cntQ  <= '0;
      value <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        FILL_IDLE: begin
          if (start) begin
            if (startLen != '0) begin
              state <= FILL_RUN;
              busy  <= 1'b1;
              addr  <= startAddr;
              cntQ  <= startLen;
              value <= startValue;
            end else begin
              state <= FILL_DONE;
              done  <= 1'b1;
            end
          end
        end
        FILL_RUN: begin
          // An abort still lets this cycle's granted write reach the RAM; it just stops here.
          if (abort) begin
            state <= FILL_IDLE;
            busy  <= 1'b0;
          end else if (grant) begin
            addr <= addr + ADDR_W'(1);
            cntQ <= cntQ - ADDR_W'(1);
            if (cntQ == ADDR_W'(1)) begin
              state <= FILL_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        FILL_DONE: state <= FILL_IDLE;
        default:   state <= FILL_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/vram_port_arbiter.sv
// CPU/fill arbiter for the VRAM CPU port: CPU first except in its ack cycle, so fill gets >= 1 of 2 cycles.
// Grant-to-ack is one cycle. VRAM_BOUNDS_CHECK_EN suppresses CPU strobes at or above VRAM_LIMIT.
module vram_port_arbiter
  import vram_pkg::*;
#(
  parameter int ADDR_W     = VRAM_ADDR_W,
  parameter int DATA_W     = VRAM_DATA_W,
  parameter int VRAM_LIMIT = vram_pkg::VRAM_LIMIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              fill_start,
  input  logic              fill_abort,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [ADDR_W-1:0] fill_len,
  input  logic [DATA_W-1:0] fill_value,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              bounds_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_strobe,
  output logic              ram_write,
  input  logic [DATA_W-1:0] ram_rdata
);
`ifdef VRAM_BOUNDS_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(VRAM_LIMIT);

  logic              cpuGrant, fillGrant, fillReq, cpuOob;
  logic              ackRead, ackOob;
  logic [ADDR_W-1:0] fillAddr;
  logic [DATA_W-1:0] fillValue;

  // cpu_ack marks the cycle after a CPU grant, which is always handed to the fill engine.
  assign cpuGrant  = cpu_req & ~cpu_ack;
  assign fillGrant = fillReq & ~cpuGrant;
  assign cpuOob    = CHECK_EN && (cpu_addr >= LIMIT);

  always_comb begin
    ram_strobe = 1'b0;
    ram_write  = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    if (cpuGrant) begin
      if (!cpuOob) begin
        ram_strobe = 1'b1;
        ram_write  = cpu_write;
        ram_addr   = cpu_addr;
        ram_wdata  = cpu_wdata;
      end
    end else if (fillGrant) begin
      ram_strobe = 1'b1;
      ram_write  = 1'b1;
      ram_addr   = fillAddr;
      ram_wdata  = fillValue;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_ack <= 1'b0;
      ackRead <= 1'b0;
      ackOob  <= 1'b0;
    end else begin
      cpu_ack <= cpuGrant;
      ackRead <= cpuGrant & ~cpu_write;
      ackOob  <= cpuGrant & cpuOob;
    end
  end

  assign bounds_err = ackOob;
  assign cpu_rdata  = ackOob ? '1 : (ackRead ? ram_rdata : '0);

  vram_fill_engine #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) uFill (
    .clk       (clk),
    .reset     (reset),
    .start     (fill_start),
    .abort     (fill_abort),
    .startAddr (fill_addr),
    .startLen  (fill_len),
    .startValue(fill_value),
    .grant     (fillGrant),
    .req       (fillReq),
    .addr      (fillAddr),
    .value     (fillValue),
    .busy      (fill_busy),
    .done      (fill_done)
  );
endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed bench for vram_port_arbiter with a behavioural RAM on the CPU port.
`timescale 1ns/1ps
module tb_vram_port_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_write;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        fill_start, fill_abort;
  logic [12:0] fill_addr, fill_len;
  logic [7:0]  fill_value;
  logic        fill_busy, fill_done, bounds_err;
  logic [12:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_strobe, ram_write;
  logic [7:0]  ram_rdata;

  int testsRun = 0;
  int testsFailed = 0;
  int ackCount = 0;
  logic memClear;
  logic [7:0] mem [0:8191];

  vram_port_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .fill_start(fill_start), .fill_abort(fill_abort), .fill_addr(fill_addr),
    .fill_len(fill_len), .fill_value(fill_value),
    .fill_busy(fill_busy), .fill_done(fill_done), .bounds_err(bounds_err),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_strobe(ram_strobe),
    .ram_write(ram_write), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (memClear) begin
      for (int i = 0; i < 8192; i++) mem[i] <= 8'hC3;
      ram_rdata <= 8'h00;
    end else begin
      if (ram_strobe && ram_write) mem[ram_addr] <= ram_wdata;
      if (ram_strobe && !ram_write) ram_rdata <= mem[ram_addr];
    end
  end

  always @(negedge clk) if (cpu_ack === 1'b1) ackCount++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [34:0] allOut();
    return {cpu_ack, cpu_rdata, fill_busy, fill_done, bounds_err,
            ram_addr, ram_wdata, ram_strobe, ram_write};
  endfunction

  // Called at posedge+1; holds the request through its ack cycle like the CPU does.
  task automatic cpu_issue(input logic w, input logic [12:0] a, input logic [7:0] d,
                           output int waitC, output logic gStrobe, output logic [12:0] gAddr,
                           output logic gWrite, output logic [7:0] gWdata,
                           output logic [7:0] rd, output logic be);
    cpu_req = 1'b1; cpu_write = w; cpu_addr = a; cpu_wdata = d;
    @(negedge clk);
    gStrobe = ram_strobe; gAddr = ram_addr; gWrite = ram_write; gWdata = ram_wdata;
    @(negedge clk);
    waitC = 1;
    while (cpu_ack !== 1'b1 && waitC < 8) begin
      @(negedge clk);
      waitC++;
    end
    rd = cpu_rdata; be = bounds_err;
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
  endtask

  task automatic start_fill(input logic [12:0] a, input logic [12:0] l, input logic [7:0] v);
    fill_start = 1'b1; fill_addr = a; fill_len = l; fill_value = v;
    @(posedge clk); #1;
    fill_start = 1'b0;
  endtask

  task automatic test_reset;
    int bad;
    testsRun++;
    if (allOut() !== 35'd0) begin
      testsFailed++; $display("FAIL reset_state: outputs=%h required 0", allOut());
    end
    reset = 1'b0;
    @(posedge clk); #1;
    start_fill(13'h0040, 13'd6, 8'h11);
    @(negedge clk);
    testsRun++;
    if ({ram_strobe, ram_addr} !== {1'b1, 13'h0040}) begin
      testsFailed++; $display("FAIL prereset_fill: strobe/addr=%h required %h", {ram_strobe, ram_addr}, {1'b1, 13'h0040});
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    testsRun++;
    if (allOut() !== 35'd0) begin
      testsFailed++; $display("FAIL async_reset: outputs=%h required 0", allOut());
    end
    @(posedge clk); #1;
    reset = 1'b0;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if ({ram_strobe, fill_busy, fill_done, cpu_ack} !== 4'b0000) bad++;
      @(posedge clk); #1;
    end
    testsRun++;
    if (bad != 0) begin
      testsFailed++; $display("FAIL idle_after_reset: active cycles=%0d required 0", bad);
    end
    start_fill(13'h0050, 13'd1, 8'h22);
    @(negedge clk);
    testsRun++;
    if ({ram_strobe, ram_write, ram_addr, ram_wdata, fill_busy} !== {2'b11, 13'h0050, 8'h22, 1'b1}) begin
      testsFailed++; $display("FAIL fill_after_reset: got %h required %h",
        {ram_strobe, ram_write, ram_addr, ram_wdata, fill_busy}, {2'b11, 13'h0050, 8'h22, 1'b1});
    end
    @(posedge clk); #1;
    @(negedge clk);
    testsRun++;
    if ({ram_strobe, fill_busy, fill_done} !== 3'b001) begin
      testsFailed++; $display("FAIL len1_done: strobe/busy/done=%b required 001", {ram_strobe, fill_busy, fill_done});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_cpu_rw;
    int w; logic gs, gw, be; logic [12:0] ga; logic [7:0] gd, rd;
    cpu_issue(1'b1, 13'h0010, 8'hA5, w, gs, ga, gw, gd, rd, be);
    testsRun++;
    if ({gs, gw, ga, gd} !== {2'b11, 13'h0010, 8'hA5}) begin
      testsFailed++; $display("FAIL cpu_write_port: got %h required %h", {gs, gw, ga, gd}, {2'b11, 13'h0010, 8'hA5});
    end
    testsRun++;
    if (w != 1 || rd !== 8'h00 || be !== 1'b0) begin
      testsFailed++; $display("FAIL cpu_write_ack: wait=%0d rdata=%h berr=%b required 1/00/0", w, rd, be);
    end
    cpu_issue(1'b0, 13'h0010, 8'h00, w, gs, ga, gw, gd, rd, be);
    testsRun++;
    if ({gs, gw, ga} !== {2'b10, 13'h0010}) begin
      testsFailed++; $display("FAIL cpu_read_port: got %h required %h", {gs, gw, ga}, {2'b10, 13'h0010});
    end
    testsRun++;
    if (w != 1 || rd !== 8'hA5) begin
      testsFailed++; $display("FAIL cpu_read_data: wait=%0d rdata=%h required 1/a5", w, rd);
    end
    @(negedge clk);
    testsRun++;
    if ({cpu_ack, cpu_rdata} !== 9'd0) begin
      testsFailed++; $display("FAIL ack_single_pulse: ack/rdata=%h required 0", {cpu_ack, cpu_rdata});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fill_basic;
    logic [12:0] expAddr;
    start_fill(13'h1E00, 13'd4, 8'h00);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      testsRun++;
      if (c <= 4) begin
        expAddr = 13'h1E00 + 13'(c - 1);
        if ({ram_strobe, ram_write, ram_addr, ram_wdata, fill_busy, fill_done} !== {2'b11, expAddr, 8'h00, 2'b10}) begin
          testsFailed++; $display("FAIL fill_cycle%0d: got %h required %h", c,
            {ram_strobe, ram_write, ram_addr, ram_wdata, fill_busy, fill_done}, {2'b11, expAddr, 8'h00, 2'b10});
        end
      end else begin
        if ({ram_strobe, fill_busy, fill_done} !== ((c == 5) ? 3'b001 : 3'b000)) begin
          testsFailed++; $display("FAIL fill_end_cycle%0d: strobe/busy/done=%b required %b", c,
            {ram_strobe, fill_busy, fill_done}, (c == 5) ? 3'b001 : 3'b000);
        end
      end
      @(posedge clk); #1;
    end
    start_fill(13'h0500, 13'd0, 8'h99);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      testsRun++;
      if ({ram_strobe, fill_busy, fill_done} !== ((c == 1) ? 3'b001 : 3'b000)) begin
        testsFailed++; $display("FAIL len0_cycle%0d: strobe/busy/done=%b required %b", c,
          {ram_strobe, fill_busy, fill_done}, (c == 1) ? 3'b001 : 3'b000);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back;
    int doneCycle = 0, fillWrites = 0, issued = 0, badWait = 0, ack0, badMem = 0;
    logic doneSeen = 1'b0;
    ack0 = ackCount;
    start_fill(13'h0100, 13'd40, 8'h5A);
    fork
      begin
        for (int c = 1; c <= 120 && !doneSeen; c++) begin
          @(negedge clk);
          if (ram_strobe && ram_write && ram_addr >= 13'h0100 && ram_addr < 13'h0128) fillWrites++;
          if (fill_done) begin doneSeen = 1'b1; doneCycle = c; end
        end
      end
      begin
        int w; logic gs, gw, be; logic [12:0] ga; logic [7:0] gd, rd;
        while (!doneSeen && issued < 70) begin
          cpu_issue(1'b1, 13'h0200 + 13'(issued), 8'(issued), w, gs, ga, gw, gd, rd, be);
          if (w != 1) badWait++;
          issued++;
        end
      end
    join
    testsRun++;
    if (!doneSeen || doneCycle > 81) begin
      testsFailed++; $display("FAIL contention_done: seen=%b cycle=%0d required done by 81", doneSeen, doneCycle);
    end
    testsRun++;
    if (fillWrites != 40) begin
      testsFailed++; $display("FAIL contention_fill_writes: got %0d required 40", fillWrites);
    end
    testsRun++;
    if (ackCount - ack0 != issued || badWait != 0) begin
      testsFailed++; $display("FAIL contention_acks: acks=%0d issued=%0d slow=%0d required equal and 0",
        ackCount - ack0, issued, badWait);
    end
    for (int i = 0; i < 40; i++) if (mem[13'h0100 + 13'(i)] !== 8'h5A) badMem++;
    if (mem[13'h0128] !== 8'hC3) badMem++;
    for (int i = 0; i < issued; i++) if (mem[13'h0200 + 13'(i)] !== 8'(i)) badMem++;
    testsRun++;
    if (badMem != 0) begin
      testsFailed++; $display("FAIL contention_memory: bad bytes=%0d required 0", badMem);
    end
  endtask

  task automatic test_wrap_abort;
    logic [12:0] expW [4] = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001};
    int bad = 0;
    start_fill(13'h1FFE, 13'd4, 8'h77);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      testsRun++;
      if (c <= 4) begin
        if ({ram_strobe, ram_addr, ram_wdata} !== {1'b1, expW[c-1], 8'h77}) begin
          testsFailed++; $display("FAIL wrap_write%0d: got %h required %h", c,
            {ram_strobe, ram_addr, ram_wdata}, {1'b1, expW[c-1], 8'h77});
        end
      end else if ({ram_strobe, fill_done} !== 2'b01) begin
        testsFailed++; $display("FAIL wrap_done: strobe/done=%b required 01", {ram_strobe, fill_done});
      end
      @(posedge clk); #1;
    end
    start_fill(13'h0300, 13'd10, 8'h33);
    @(negedge clk);
    @(posedge clk); #1;
    fill_abort = 1'b1;
    @(negedge clk);
    testsRun++;
    if ({ram_strobe, ram_addr, ram_wdata} !== {1'b1, 13'h0301, 8'h33}) begin
      testsFailed++; $display("FAIL abort_last_write: got %h required %h",
        {ram_strobe, ram_addr, ram_wdata}, {1'b1, 13'h0301, 8'h33});
    end
    @(posedge clk); #1;
    fill_abort = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if ({ram_strobe, fill_busy, fill_done} !== 3'b000) bad++;
      @(posedge clk); #1;
    end
    testsRun++;
    if (bad != 0 || mem[13'h0301] !== 8'h33 || mem[13'h0302] !== 8'hC3) begin
      testsFailed++; $display("FAIL abort_quiet: active=%0d m301=%h m302=%h required 0/33/c3",
        bad, mem[13'h0301], mem[13'h0302]);
    end
  endtask

  task automatic test_bounds;
    int w; logic gs, gw, be; logic [12:0] ga; logic [7:0] gd, rd;
    cpu_issue(1'b0, 13'h1E00, 8'h00, w, gs, ga, gw, gd, rd, be);
    testsRun++;
`ifdef VRAM_BOUNDS_CHECK_EN
    if (w != 1 || {gs, rd, be} !== {1'b0, 8'hFF, 1'b1}) begin
      testsFailed++; $display("FAIL oob_read: wait=%0d strobe/rdata/berr=%h required 1/%h",
        w, {gs, rd, be}, {1'b0, 8'hFF, 1'b1});
    end
`else
    if (w != 1 || {gs, rd, be} !== {1'b1, 8'h00, 1'b0}) begin
      testsFailed++; $display("FAIL oob_read: wait=%0d strobe/rdata/berr=%h required 1/%h",
        w, {gs, rd, be}, {1'b1, 8'h00, 1'b0});
    end
`endif
    cpu_issue(1'b0, 13'h1DFF, 8'h00, w, gs, ga, gw, gd, rd, be);
    testsRun++;
    if (w != 1 || {gs, ga, rd, be} !== {1'b1, 13'h1DFF, 8'hC3, 1'b0}) begin
      testsFailed++; $display("FAIL inbound_read: wait=%0d got %h required %h",
        w, {gs, ga, rd, be}, {1'b1, 13'h1DFF, 8'hC3, 1'b0});
    end
    @(negedge clk);
    testsRun++;
    if ({bounds_err, cpu_ack} !== 2'b00) begin
      testsFailed++; $display("FAIL berr_idle: berr/ack=%b required 00", {bounds_err, cpu_ack});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; memClear = 1'b1;
    cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    fill_start = 1'b0; fill_abort = 1'b0; fill_addr = '0; fill_len = '0; fill_value = '0;
    repeat (3) @(posedge clk);
    #1;
    memClear = 1'b0;
    test_reset();
    test_cpu_rw();
    test_fill_basic();
    test_back_to_back();
    test_wrap_abort();
    test_bounds();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
